// File: rtl/ps2_host_ctrl.sv
// -----------------------------------------------------------------------------
// ps2_host_ctrl
//   Host-side PS/2 line controller. It receives device frames and reports each
//   verified scan byte, keeping the last two bytes for the hex displays. It also
//   sends host-to-device command frames: clock inhibit, request-to-send, bit
//   shifting on device clock edges, and the ACK check. The bus carries one
//   direction at a time. Both pins are open-drain and are driven through output
//   enables.
//
// Ports
//   clk         system clock (50 MHz)
//   reset_n     asynchronous active-low reset
//   ps2_clk_i   PS2_CLK pin level (asynchronous)
//   ps2_dat_i   PS2_DATA pin level (asynchronous)
//   ps2_clk_oe  1 = pull PS2_CLK low, 0 = release
//   ps2_dat_oe  1 = pull PS2_DATA low, 0 = release
//   cmd_data    command byte to send
//   cmd_valid   command request, held until accepted
//   cmd_ready   high only in IDLE when no receive frame is starting
//   rx_data     last good received byte
//   rx_valid    1-cycle pulse, rx_data has just been updated
//   rx_err      1-cycle pulse, receive parity/stop/timeout error
//   tx_done     1-cycle pulse, command frame sent and ACKed
//   tx_err      1-cycle pulse, command frame not ACKed or timed out
//   busy        high in every state except IDLE
//   last_codes  {previous byte, latest byte}
// -----------------------------------------------------------------------------
module ps2_host_ctrl #(
    parameter int INHIBIT_CYC = 5000,
    parameter int TIMEOUT_CYC = 1000000,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ps2_clk_i,
    input  logic        ps2_dat_i,
    output logic        ps2_clk_oe,
    output logic        ps2_dat_oe,
    input  logic [7:0]  cmd_data,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        rx_err,
    output logic        tx_done,
    output logic        tx_err,
    output logic        busy,
    output logic [15:0] last_codes
);

    localparam int CNT_MAX = (INHIBIT_CYC > TIMEOUT_CYC) ? INHIBIT_CYC : TIMEOUT_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYC - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        IDLE, RX, TX_INH, TX_RTS, TX_BITS, TX_ACK, TX_REL
    } state_t;

    // ---------------------------------------------------------------- sync
    logic [SYNC_STAGES-1:0] clk_sync, dat_sync;
    logic                   clk_prev;
    logic                   clk_s, dat_s, fall;

    // NOTE: the synchronizers reset to 1 (idle bus level) so that releasing
    // reset cannot look like a falling clock edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync <= '1;
            dat_sync <= '1;
            clk_prev <= 1'b1;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge values and the chain shifts by one.
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk_i};
            dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_dat_i};
            clk_prev <= clk_sync[SYNC_STAGES-1];
        end
    end

    assign clk_s = clk_sync[SYNC_STAGES-1];
    assign dat_s = dat_sync[SYNC_STAGES-1];
    assign fall  = clk_prev & ~clk_s;

    // ---------------------------------------------------------------- state
    state_t             state, state_n;
    logic [3:0]         bit_cnt, bit_cnt_n;
    logic [7:0]         shreg, shreg_n;
    logic               par_bit, par_bit_n;
    logic [7:0]         tx_byte, tx_byte_n;
    logic               dat_drive, dat_drive_n;
    logic               ack_seen, ack_seen_n;
    logic [CNT_W-1:0]   tick, tick_n;
    logic [7:0]         rx_data_n;
    logic [15:0]        last_codes_n;
    logic               rx_valid_n, rx_err_n, tx_done_n, tx_err_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            par_bit    <= 1'b0;
            tx_byte    <= '0;
            dat_drive  <= 1'b0;
            ack_seen   <= 1'b0;
            tick       <= '0;
            rx_data    <= '0;
            last_codes <= '0;
            rx_valid   <= 1'b0;
            rx_err     <= 1'b0;
            tx_done    <= 1'b0;
            tx_err     <= 1'b0;
        end else begin
            state      <= state_n;
            bit_cnt    <= bit_cnt_n;
            shreg      <= shreg_n;
            par_bit    <= par_bit_n;
            tx_byte    <= tx_byte_n;
            dat_drive  <= dat_drive_n;
            ack_seen   <= ack_seen_n;
            tick       <= tick_n;
            rx_data    <= rx_data_n;
            last_codes <= last_codes_n;
            rx_valid   <= rx_valid_n;
            rx_err     <= rx_err_n;
            tx_done    <= tx_done_n;
            tx_err     <= tx_err_n;
        end
    end

    // ---------------------------------------------------------------- next state
    always_comb begin
        // NOTE: every signal gets a default first, so no path through the case
        // can leave a value unassigned and infer a latch.
        state_n      = state;
        bit_cnt_n    = bit_cnt;
        shreg_n      = shreg;
        par_bit_n    = par_bit;
        tx_byte_n    = tx_byte;
        dat_drive_n  = dat_drive;
        ack_seen_n   = ack_seen;
        tick_n       = tick;
        rx_data_n    = rx_data;
        last_codes_n = last_codes;
        rx_valid_n   = 1'b0;
        rx_err_n     = 1'b0;
        tx_done_n    = 1'b0;
        tx_err_n     = 1'b0;

        unique case (state)
            IDLE: begin
                tick_n = '0;
                if (fall && !dat_s) begin
                    // A start bit beats a pending command in the same cycle.
                    state_n   = RX;
                    bit_cnt_n = '0;
                end else if (cmd_valid) begin
                    tx_byte_n = cmd_data;
                    state_n   = TX_INH;
                end
            end

            RX: begin
                if (fall) begin
                    tick_n = '0;
                    if (bit_cnt < 4'd8) begin
                        shreg_n   = {dat_s, shreg[7:1]};
                        bit_cnt_n = bit_cnt + 4'd1;
                    end else if (bit_cnt == 4'd8) begin
                        par_bit_n = dat_s;
                        bit_cnt_n = 4'd9;
                    end else begin
                        state_n = IDLE;
                        // Odd parity over data+parity, and stop must be high.
                        if ((^{shreg, par_bit}) && dat_s) begin
                            rx_data_n    = shreg;
                            last_codes_n = {last_codes[7:0], shreg};
                            rx_valid_n   = 1'b1;
                        end else begin
                            rx_err_n = 1'b1;
                        end
                    end
                end else if (tick == TMO_LAST) begin
                    state_n  = IDLE;
                    rx_err_n = 1'b1;
                end else begin
                    tick_n = tick + CNT_W'(1);
                end
            end

            TX_INH: begin
                if (tick == INH_LAST) begin
                    tick_n  = '0;
                    state_n = TX_RTS;
                end else begin
                    tick_n = tick + CNT_W'(1);
                end
            end

            TX_RTS: begin
                // Start bit stays on the data line once the clock is released.
                state_n     = TX_BITS;
                bit_cnt_n   = '0;
                dat_drive_n = 1'b1;
                tick_n      = '0;
            end

            TX_BITS: begin
                if (fall) begin
                    tick_n = '0;
                    if (bit_cnt < 4'd8) begin
                        dat_drive_n = ~tx_byte[bit_cnt[2:0]];
                        bit_cnt_n   = bit_cnt + 4'd1;
                    end else if (bit_cnt == 4'd8) begin
                        // Odd parity bit is ~^data; driving low means a 0 bit.
                        dat_drive_n = ^tx_byte;
                        bit_cnt_n   = 4'd9;
                    end else begin
                        dat_drive_n = 1'b0;           // stop bit = released line
                        state_n     = TX_ACK;
                    end
                end else if (tick == TMO_LAST) begin
                    dat_drive_n = 1'b0;
                    state_n     = IDLE;
                    tx_err_n    = 1'b1;
                end else begin
                    tick_n = tick + CNT_W'(1);
                end
            end

            TX_ACK: begin
                if (fall) begin
                    ack_seen_n = ~dat_s;
                    state_n    = TX_REL;
                end else if (tick == TMO_LAST) begin
                    state_n  = IDLE;
                    tx_err_n = 1'b1;
                end else begin
                    tick_n = tick + CNT_W'(1);
                end
            end

            TX_REL: begin
                if (clk_s && dat_s) begin
                    state_n   = IDLE;
                    tx_done_n = ack_seen;
                    tx_err_n  = ~ack_seen;
                end
            end

            default: state_n = IDLE;
        endcase
    end

    // ---------------------------------------------------------------- outputs
    // Decoded from state so that an asynchronous reset releases both lines at once.
    assign ps2_clk_oe = (state == TX_INH) || (state == TX_RTS);
    assign ps2_dat_oe = (state == TX_RTS) || ((state == TX_BITS) && dat_drive);
    assign busy       = (state != IDLE);
    assign cmd_ready  = (state == IDLE) && !(fall && !dat_s);

endmodule

// File: tb/tb_ps2_host_ctrl.sv
// -----------------------------------------------------------------------------
// tb_ps2_host_ctrl
//   Bench for ps2_host_ctrl. A simple PS/2 device model drives the open-drain
//   lines. Every expected pulse (rx_valid, rx_err, tx_done, tx_err) is queued
//   when its stimulus starts. A monitor pops and compares each pulse as the DUT
//   produces it.
// -----------------------------------------------------------------------------
module tb_ps2_host_ctrl;

    localparam int INHIBIT_CYC = 5000;
    localparam int TIMEOUT_CYC = 3000;
    localparam int HALF        = 15;     // device clock half period in clk cycles

    typedef enum int {EV_RX, EV_RXERR, EV_TXDONE, EV_TXERR} ev_kind_e;
    typedef struct {
        ev_kind_e    kind;
        logic [15:0] codes;     // expected last_codes; [7:0] is expected rx_data
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        dev_clk = 1'b1;
    logic        dev_dat = 1'b1;
    logic        ps2_clk_i, ps2_dat_i;
    logic        ps2_clk_oe, ps2_dat_oe;
    logic [7:0]  cmd_data = 8'h00;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  rx_data;
    logic        rx_valid, rx_err, tx_done, tx_err, busy;
    logic [15:0] last_codes;

    int          total = 0;
    int          bad = 0;
    exp_t        sb[$];
    logic [15:0] m_codes = 16'h0000;

    // Open-drain wired-AND of the device and host drivers.
    assign ps2_clk_i = dev_clk & ~ps2_clk_oe;
    assign ps2_dat_i = dev_dat & ~ps2_dat_oe;

    always #5 clk = ~clk;

    ps2_host_ctrl #(
        .INHIBIT_CYC (INHIBIT_CYC),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ps2_clk_i  (ps2_clk_i),
        .ps2_dat_i  (ps2_dat_i),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe),
        .cmd_data   (cmd_data),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_err     (rx_err),
        .tx_done    (tx_done),
        .tx_err     (tx_err),
        .busy       (busy),
        .last_codes (last_codes)
    );

    // ---------------------------------------------------------------- monitor
    ev_kind_e mon_got;
    exp_t     mon_e;
    int       mon_n;

    always @(negedge clk) begin
        if (reset_n && (rx_valid || rx_err || tx_done || tx_err)) begin
            mon_n   = int'(rx_valid) + int'(rx_err) + int'(tx_done) + int'(tx_err);
            mon_got = rx_valid ? EV_RX : rx_err ? EV_RXERR : tx_done ? EV_TXDONE : EV_TXERR;
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_pulse: got %s, none was expected", mon_got.name());
            end else begin
                mon_e = sb.pop_front();
                if (mon_got !== mon_e.kind || mon_n != 1) begin
                    bad++;
                    $display("FAIL pulse_kind: got %s (%0d pulses), required %s",
                             mon_got.name(), mon_n, mon_e.kind.name());
                end
                if (mon_e.kind == EV_RX || mon_e.kind == EV_RXERR) begin
                    total++;
                    if (rx_data !== mon_e.codes[7:0]) begin
                        bad++;
                        $display("FAIL rx_data: got %h, required %h", rx_data, mon_e.codes[7:0]);
                    end
                    total++;
                    if (last_codes !== mon_e.codes) begin
                        bad++;
                        $display("FAIL last_codes: got %h, required %h", last_codes, mon_e.codes);
                    end
                end
            end
        end
    end

    // ---------------------------------------------------------------- helpers
    task automatic push_rx(input logic [7:0] b);
        m_codes = {m_codes[7:0], b};
        sb.push_back('{EV_RX, m_codes});
    endtask

    task automatic push_ev(input ev_kind_e k);
        sb.push_back('{k, m_codes});
    endtask

    // Device-to-host frame; only the first nbits of start/data/parity/stop are sent.
    task automatic dev_frame(input logic [7:0] b, input logic par, input logic stp, input int nbits);
        logic [10:0] f;
        f = {stp, par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            dev_dat = f[i];
            repeat (HALF) @(negedge clk);
            dev_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            dev_clk = 1'b1;
        end
        dev_dat = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < TIMEOUT_CYC + 500) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL %s_drain: %0d expected pulses never arrived", name, sb.size());
            sb.delete();
        end
    endtask

    // Issues cmd and returns on the first TX_INH cycle (negedge).
    task automatic send_cmd(input logic [7:0] c, input string name);
        @(negedge clk);
        cmd_data  = c;
        cmd_valid = 1'b1;
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s_cmd_ready: got %b, required 1", name, cmd_ready);
        end
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Inhibit length, RTS, then the released clock.
    task automatic check_inhibit(input string name);
        int n;
        n = 0;
        while (ps2_clk_oe && !ps2_dat_oe && n < 2 * INHIBIT_CYC) begin
            n++;
            @(negedge clk);
        end
        total++;
        if (n != INHIBIT_CYC) begin
            bad++;
            $display("FAIL %s_inhibit_len: got %0d cycles, required %0d", name, n, INHIBIT_CYC);
        end
        total++;
        if (!(ps2_clk_oe === 1'b1 && ps2_dat_oe === 1'b1)) begin
            bad++;
            $display("FAIL %s_rts: got clk_oe=%b dat_oe=%b, required 1 1", name, ps2_clk_oe, ps2_dat_oe);
        end
        @(negedge clk);
        total++;
        if (!(ps2_clk_oe === 1'b0 && ps2_dat_i === 1'b0)) begin
            bad++;
            $display("FAIL %s_start_bit: got clk_oe=%b dat=%b, required 0 0", name, ps2_clk_oe, ps2_dat_i);
        end
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        reset_n = 1'b0;
        repeat (4) @(negedge clk);
        total++;
        if ({ps2_clk_oe, ps2_dat_oe, rx_valid, rx_err, tx_done, tx_err, busy} !== 7'b0 ||
            rx_data !== 8'h00 || last_codes !== 16'h0000) begin
            bad++;
            $display("FAIL reset_outputs: got oe=%b%b pulses=%b%b%b%b busy=%b rx=%h codes=%h, required all 0",
                     ps2_clk_oe, ps2_dat_oe, rx_valid, rx_err, tx_done, tx_err, busy, rx_data, last_codes);
        end
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        total++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle: got cmd_ready=%b busy=%b, required 1 0", cmd_ready, busy);
        end
    endtask

    task automatic test_rx_basic();
        push_rx(8'h1C);
        dev_frame(8'h1C, 1'b0, 1'b1, 11);
        wait_drain("rx_1c");
        push_rx(8'hF0);
        dev_frame(8'hF0, 1'b1, 1'b1, 11);
        push_rx(8'h1C);
        dev_frame(8'h1C, 1'b0, 1'b1, 11);
        wait_drain("rx_f01c");
        total++;
        if (last_codes !== 16'hF01C) begin
            bad++;
            $display("FAIL rx_history: got %h, required f01c", last_codes);
        end
    endtask

    task automatic test_rx_errors();
        push_ev(EV_RXERR);
        dev_frame(8'h1C, 1'b1, 1'b1, 11);          // bad parity
        wait_drain("rx_parity");
        push_ev(EV_RXERR);
        dev_frame(8'h1C, 1'b0, 1'b0, 11);          // bad stop
        wait_drain("rx_stop");
    endtask

    task automatic test_tx(input logic ack_en, input string name);
        logic [9:0] exp_bits;
        exp_bits = 10'b11_1110_1101;               // 0xED LSB first, parity 1, stop 1
        push_ev(ack_en ? EV_TXDONE : EV_TXERR);
        send_cmd(8'hED, name);
        check_inhibit(name);
        for (int i = 0; i < 10; i++) begin
            repeat (HALF) @(negedge clk);
            dev_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            total++;
            if (ps2_dat_i !== exp_bits[i]) begin
                bad++;
                $display("FAIL %s_bit%0d: got %b, required %b", name, i, ps2_dat_i, exp_bits[i]);
            end
            dev_clk = 1'b1;
        end
        if (ack_en) dev_dat = 1'b0;
        repeat (HALF) @(negedge clk);
        dev_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        dev_clk = 1'b1;
        dev_dat = 1'b1;
        wait_drain(name);
        repeat (4) @(negedge clk);
        total++;
        if (busy !== 1'b0 || ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b0 || cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s_idle: got busy=%b oe=%b%b ready=%b, required 0 00 1",
                     name, busy, ps2_clk_oe, ps2_dat_oe, cmd_ready);
        end
    endtask

    task automatic test_rx_timeout();
        int n;
        push_ev(EV_RXERR);
        dev_frame(8'h1C, 1'b0, 1'b1, 5);           // start + 4 data bits
        n = 2 * HALF;                              // cycles since the last falling edge
        while (!rx_err && n < TIMEOUT_CYC + 200) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n < TIMEOUT_CYC || n > TIMEOUT_CYC + 10) begin
            bad++;
            $display("FAIL rx_timeout_time: got %0d cycles, required %0d..%0d",
                     n, TIMEOUT_CYC, TIMEOUT_CYC + 10);
        end
        wait_drain("rx_timeout");
        push_rx(8'h5A);
        dev_frame(8'h5A, 1'b1, 1'b1, 11);
        wait_drain("rx_after_timeout");
    endtask

    task automatic test_back_to_back();
        push_rx(8'hE0);
        push_rx(8'h75);
        push_rx(8'h12);
        dev_frame(8'hE0, 1'b0, 1'b1, 11);
        dev_frame(8'h75, 1'b0, 1'b1, 11);
        dev_frame(8'h12, 1'b1, 1'b1, 11);
        wait_drain("back_to_back");
    endtask

    task automatic test_reset_mid_tx();
        send_cmd(8'hED, "rst_tx");
        check_inhibit("rst_tx");
        for (int i = 0; i < 2; i++) begin             // data bits 0 (1) and 1 (0)
            repeat (HALF) @(negedge clk);
            dev_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            dev_clk = 1'b1;
        end
        total++;
        if (ps2_dat_oe !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL rst_tx_pre: got dat_oe=%b busy=%b, required 1 1", ps2_dat_oe, busy);
        end
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        total++;
        if (ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b0) begin
            bad++;
            $display("FAIL rst_tx_release: got clk_oe=%b dat_oe=%b, required 0 0", ps2_clk_oe, ps2_dat_oe);
        end
        m_codes = 16'h0000;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        total++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || last_codes !== 16'h0000 || rx_data !== 8'h00) begin
            bad++;
            $display("FAIL rst_tx_after: got ready=%b busy=%b codes=%h rx=%h, required 1 0 0000 00",
                     cmd_ready, busy, last_codes, rx_data);
        end
    endtask

    // ---------------------------------------------------------------- sequence
    initial begin
        test_reset();
        test_rx_basic();
        test_rx_errors();
        test_tx(1'b1, "tx_ack");
        test_tx(1'b0, "tx_noack");
        test_rx_timeout();
        test_back_to_back();
        test_reset_mid_tx();
        repeat (20) @(negedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL leftover_expected: got %0d pending, required 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
